// File: rtl/gate_lib_pkg.sv
// Shared definitions for the gate library test sequencers:
// sweep FSM state encoding and reference truth tables for the basic gates.
package gate_lib_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } sweep_state_t;

  // Truth tables: bit i is the expected output for input vector i (bit 0 = input A)
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;
  localparam logic [7:0] TT_XOR3  = 8'h96;

endpackage

// File: rtl/gate_sweep_timer.sv
// Loadable down-counter that measures the settle time of each sweep vector.
module gate_sweep_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and stick at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for one combinational gate under test:
// drives every input vector in ascending order, waits SETTLE cycles,
// samples the gate output and checks it against the EXPECT truth table.
module gate_sweep_ctrl
  import gate_lib_pkg::*;
#(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]   EXPECT = TT_OR2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            gate_y,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int TW = $clog2(SETTLE) + 1;
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

  sweep_state_t state;

  logic          timer_load;
  logic          timer_dec;
  logic          timer_zero;
  logic          last_vec;
  logic          mismatch;
  logic [N_IN:0] err_next;

  assign last_vec = &gate_in;
  assign mismatch = (gate_y != EXPECT[gate_in]);
  assign err_next = mismatch ? (err_count + ERR_ONE) : err_count;

  // The settle timer reloads whenever a new vector is put on the gate
  assign timer_load = ((state == IDLE) && start) || ((state == SAMPLE) && !last_vec);
  assign timer_dec  = (state == DRIVE) && !timer_zero;

  assign busy = (state == DRIVE) || (state == SAMPLE);

  gate_sweep_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  // Sweep FSM with vector counter, mismatch checker and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gate_in    <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            pass       <= 1'b0;
            gate_in    <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (timer_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_vec   <= gate_in;
            fail_valid <= 1'b1;
          end
          if (last_vec) begin
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end else begin
            gate_in <= gate_in + VEC_ONE;
            state   <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed testbench for gate_sweep_ctrl: a 2-input instance checked with an
// OR, stuck-at-0 and AND gate model, and a 3-input XOR instance with SETTLE=1.
module tb_gate_sweep_ctrl;
  import gate_lib_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  int         gut_mode = 0;

  logic       gate_y_a;
  logic [1:0] gate_in_a;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic [2:0] err_count_a;
  logic [1:0] fail_vec_a;

  logic       gate_y_b;
  logic [2:0] gate_in_b;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [3:0] err_count_b;
  logic [2:0] fail_vec_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate models: 0 = OR, 1 = output stuck at 0, 2 = AND
  always_comb begin
    gate_y_a = 1'b0;
    case (gut_mode)
      0:       gate_y_a = gate_in_a[0] | gate_in_a[1];
      2:       gate_y_a = gate_in_a[0] & gate_in_a[1];
      default: gate_y_a = 1'b0;
    endcase
  end

  assign gate_y_b = ^gate_in_b;

  gate_sweep_ctrl #(
    .N_IN(2), .SETTLE(2), .EXPECT(TT_OR2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .gate_y(gate_y_a),
    .gate_in(gate_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .fail_valid(fail_valid_a), .fail_vec(fail_vec_a)
  );

  gate_sweep_ctrl #(
    .N_IN(3), .SETTLE(1), .EXPECT(TT_XOR3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_y(gate_y_b),
    .gate_in(gate_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and drive the start inputs just after it
  task automatic applyStimulus(input logic sa, input logic sb);
    @(posedge clk);
    #1;
    start_a = sa;
    start_b = sb;
  endtask

  // Full sweep on the 2-input instance; start is driven after edge 0 and captured at edge 1
  task automatic sweepA(input string tag, input int exp_err, input int exp_fv,
                        input int exp_fvec, input int exp_pass, input bit extra_start);
    int pulses;
    pulses = 0;
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      start_a = extra_start && (e == 4);
      if (done_a) pulses++;
      if (e <= 12) begin
        checkOutput({tag, " gate_in"}, gate_in_a, (e - 1) / 3);
        checkOutput({tag, " busy"}, busy_a, 1);
        checkOutput({tag, " done_early"}, done_a, 0);
      end else if (e == 13) begin
        checkOutput({tag, " done"}, done_a, 1);
        checkOutput({tag, " busy_end"}, busy_a, 0);
        checkOutput({tag, " gate_in_end"}, gate_in_a, 3);
        checkOutput({tag, " err_count"}, err_count_a, exp_err);
        checkOutput({tag, " fail_valid"}, fail_valid_a, exp_fv);
        checkOutput({tag, " fail_vec"}, fail_vec_a, exp_fvec);
        checkOutput({tag, " pass"}, pass_a, exp_pass);
      end
    end
    checkOutput({tag, " done_pulses"}, pulses, 1);
    checkOutput({tag, " pass_hold"}, pass_a, exp_pass);
    checkOutput({tag, " err_hold"}, err_count_a, exp_err);
  endtask

  initial begin
    int pulses;

    #1 rst = 1'b1;
    #10;
    checkOutput("reset gate_in", gate_in_a, 0);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset done", done_a, 0);
    checkOutput("reset pass", pass_a, 0);
    checkOutput("reset err_count", err_count_a, 0);
    checkOutput("reset fail_valid", fail_valid_a, 0);
    checkOutput("reset fail_vec", fail_vec_a, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] OR gate sweep");
    gut_mode = 0;
    sweepA("or2", 0, 0, 0, 1, 1'b0);

    $display("[TB] stuck-at-0 gate sweep");
    gut_mode = 1;
    sweepA("tie0", 3, 1, 1, 0, 1'b0);

    $display("[TB] AND gate against OR table");
    gut_mode = 2;
    sweepA("and2", 2, 1, 1, 0, 1'b0);

    $display("[TB] second start while busy");
    gut_mode = 0;
    sweepA("restart", 0, 0, 0, 1, 1'b1);

    $display("[TB] reset during DRIVE of vector 2");
    gut_mode = 1;
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
    end
    checkOutput("abort pre gate_in", gate_in_a, 2);
    checkOutput("abort pre err_count", err_count_a, 1);
    checkOutput("abort pre fail_valid", fail_valid_a, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort gate_in", gate_in_a, 0);
    checkOutput("abort busy", busy_a, 0);
    checkOutput("abort done", done_a, 0);
    checkOutput("abort pass", pass_a, 0);
    checkOutput("abort err_count", err_count_a, 0);
    checkOutput("abort fail_valid", fail_valid_a, 0);
    checkOutput("abort fail_vec", fail_vec_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done_a) pulses++;
    end
    checkOutput("abort no_done", pulses, 0);
    checkOutput("abort idle busy", busy_a, 0);
    gut_mode = 0;
    sweepA("recover", 0, 0, 0, 1, 1'b0);

    $display("[TB] 3-input XOR sweep, SETTLE=1");
    applyStimulus(1'b0, 1'b1);
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk);
      #1;
      start_b = 1'b0;
      if (e <= 16) begin
        checkOutput("xor3 gate_in", gate_in_b, (e - 1) / 2);
        checkOutput("xor3 busy", busy_b, 1);
        checkOutput("xor3 done_early", done_b, 0);
      end else if (e == 17) begin
        checkOutput("xor3 done", done_b, 1);
        checkOutput("xor3 gate_in_end", gate_in_b, 7);
        checkOutput("xor3 pass", pass_b, 1);
        checkOutput("xor3 err_count", err_count_b, 0);
        checkOutput("xor3 fail_valid", fail_valid_b, 0);
      end else begin
        checkOutput("xor3 done_clear", done_b, 0);
        checkOutput("xor3 busy_clear", busy_b, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
